// File: rtl/led_scheduler.sv
// Five-LED pattern sequencer with global PWM brightness for the iCEstick.
// Commands arrive on a valid/ready port and take effect only on step-tick boundaries.
//
//   state  | meaning
//   S_IDLE | mode OFF, LEDs dark; a command applies immediately
//   S_RUN  | pattern advances on each tick; a command is latched
//   S_PEND | latched command waits for the next tick, cmd_ready low
module led_scheduler #(
  parameter int STEP_DIV = 3000000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic                busy,
  output logic                D1,
  output logic                D2,
  output logic                D3,
  output logic                D4,
  output logic                D5
);

  localparam int STEP_W = $clog2(STEP_DIV);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ALL   = 2'd1;
  localparam logic [1:0] M_CHASE = 2'd2;
  localparam logic [1:0] M_BLINK = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [PWM_BITS-1:0] r_level;
  logic [1:0]          r_pend_mode;
  logic [PWM_BITS-1:0] r_pend_level;
  logic [4:0]          r_pattern;
  logic [4:0]          r_led;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_busy;
  logic                r_ready;

  logic w_tick;
  logic w_xfer;
  logic w_pwm_on;

  assign w_tick   = (r_step_cnt == STEP_LAST);
  assign w_xfer   = cmd_valid & r_ready;
  assign w_pwm_on = (r_pwm_cnt <= r_level);

  function automatic logic [4:0] entry_pattern(input logic [1:0] m);
    case (m)
      M_ALL:   entry_pattern = 5'b11111;
      M_CHASE: entry_pattern = 5'b10001;
      M_BLINK: entry_pattern = 5'b11111;
      default: entry_pattern = 5'b00000;
    endcase
  endfunction

  // Pattern bit 0 drives D1; CHASE rotates D1..D4 and keeps D5 lit.
  function automatic logic [4:0] next_pattern(input logic [1:0] m, input logic [4:0] p);
    case (m)
      M_CHASE: next_pattern = {1'b1, p[2:0], p[3]};
      M_BLINK: next_pattern = ~p;
      default: next_pattern = p;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_mode       <= M_OFF;
      r_level      <= '1;
      r_pend_mode  <= M_OFF;
      r_pend_level <= '1;
      r_pattern    <= 5'b00000;
      r_led        <= 5'b00000;
      r_step_cnt   <= '0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_led      <= r_pattern & {5{w_pwm_on}};
      r_step_cnt <= w_tick ? '0 : r_step_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_mode     <= cmd_mode;
            r_level    <= cmd_level;
            r_pattern  <= entry_pattern(cmd_mode);
            r_step_cnt <= '0;
            if (cmd_mode != M_OFF) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_pend_mode  <= cmd_mode;
            r_pend_level <= cmd_level;
            r_busy       <= 1'b1;
            r_ready      <= 1'b0;
            r_state      <= S_PEND;
          end
          // A command landing on the tick cycle is only latched; the step still advances.
          if (w_tick) r_pattern <= next_pattern(r_mode, r_pattern);
        end
        S_PEND: begin
          if (w_tick) begin
            r_mode     <= r_pend_mode;
            r_level    <= r_pend_level;
            r_pattern  <= entry_pattern(r_pend_mode);
            r_step_cnt <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= (r_pend_mode == M_OFF) ? S_IDLE : S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign D1        = r_led[0];
  assign D2        = r_led[1];
  assign D3        = r_led[2];
  assign D4        = r_led[3];
  assign D5        = r_led[4];

endmodule

// File: tb/tb_led_scheduler.sv
// Self-checking bench for led_scheduler (STEP_DIV=8): expected {ready,busy,D5..D1}
// words are queued per cycle when a command is driven and compared as cycles elapse.
module tb_led_scheduler;

  logic       clk;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_level;
  logic       busy;
  logic       D1, D2, D3, D4, D5;

  led_scheduler #(.STEP_DIV(8), .PWM_BITS(4)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_level(cmd_level),
    .busy(busy),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tst;
    int cyc;
    int exp;
  } sb_t;

  sb_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle index since reset release; equals pwm_cnt (mod 16) during that cycle.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc_cnt <= 0;
    else       cyc_cnt <= cyc_cnt + 1;
  end

  function automatic int obs_word();
    return int'({cmd_ready, busy, D5, D4, D3, D2, D1});
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        sb_t e;
        e = q.pop_front();
        chk($sformatf("sb_t%0d_c%0d", e.tst, e.cyc), obs_word(), e.exp);
      end
    end
  end

  // Pattern k steps after a mode is applied, bit order {D5..D1}.
  function automatic logic [4:0] exp_pat(input int mode, input int k);
    logic [3:0] one;
    one = 4'b0001;
    case (mode)
      1:       return 5'b11111;
      2:       return {1'b1, one << (k % 4)};
      3:       return (k % 2 == 0) ? 5'b11111 : 5'b00000;
      default: return 5'b00000;
    endcase
  endfunction

  // D seen after edge c reflects pattern/level/pwm during cycle c-1.
  function automatic int exp_word(input bit rdy, input bit bsy, input logic [4:0] pat,
                                  input int c, input int lvl);
    logic on;
    on = (((c - 1) % 16) <= lvl);
    return int'({rdy, bsy, pat & {5{on}}});
  endfunction

  task automatic push(input int tst, input int c, input int exp);
    sb_t e;
    e.tst = tst; e.cyc = c; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc_cnt < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Called at a negedge; the transfer happens at edge n.
  task automatic send(input logic [1:0] m, input logic [3:0] l, output int n);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_level = l;
    n = cyc_cnt + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int a, m, t, n;

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode = 2'd1;
    cmd_level = 4'd15;

    // 1: reset with cmd_valid held high
    repeat (3) @(negedge clk);
    chk("rst_leds", int'({D5, D4, D3, D2, D1}), 0);
    chk("rst_busy", int'(busy), 0);
    rstn = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rel_ready", int'(cmd_ready), 1);
    chk("rel_busy", int'(busy), 0);

    // 2: ALL at full brightness from IDLE
    send(2'd1, 4'd15, a);
    for (int c = a + 2; c <= a + 33; c++)
      push(2, c, exp_word(1'b1, 1'b0, exp_pat(1, (c - 1 - a) / 8), c, 15));
    wait_cyc(a + 34);

    // 3: CHASE from IDLE
    do_reset();
    wait_cyc(1);
    send(2'd2, 4'd15, a);
    for (int c = a + 2; c <= a + 41; c++)
      push(3, c, exp_word(1'b1, 1'b0, exp_pat(2, (c - 1 - a) / 8), c, 15));

    // 4: BLINK requested mid-step, second command refused while pending
    wait_cyc(a + 42);
    send(2'd3, 4'd15, m);
    t = a + ((m - a) / 8 + 1) * 8;
    for (int c = m + 1; c <= t + 24; c++) begin
      if (c - 1 < t)
        push(4, c, exp_word(c >= t, c < t, exp_pat(2, (c - 1 - a) / 8), c, 15));
      else
        push(4, c, exp_word(1'b1, 1'b0, exp_pat(3, (c - 1 - t) / 8), c, 15));
    end
    wait_cyc(m + 2);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_level = 4'd0;
    wait_cyc(t - 1);
    cmd_valid = 1'b0;
    wait_cyc(t + 25);

    // 5: ALL at level 3, then level 0 applied through PEND
    do_reset();
    wait_cyc(1);
    send(2'd1, 4'd3, a);
    for (int c = a + 2; c <= a + 33; c++)
      push(5, c, exp_word(1'b1, 1'b0, 5'b11111, c, 3));
    wait_cyc(a + 33);
    send(2'd1, 4'd0, m);
    t = a + ((m - a) / 8 + 1) * 8;
    for (int c = m + 1; c <= t + 32; c++)
      push(5, c, exp_word(c >= t, c < t, 5'b11111, c, (c - 1 >= t) ? 0 : 3));
    wait_cyc(t + 33);

    // 6: OFF transferred on the tick cycle of a CHASE step
    do_reset();
    wait_cyc(1);
    send(2'd2, 4'd15, a);
    m = a + 16;
    t = a + 24;
    for (int c = a + 2; c <= t + 10; c++) begin
      if (c - 1 < t)
        push(6, c, exp_word(!(c >= m && c < t), (c >= m && c < t),
                            exp_pat(2, (c - 1 - a) / 8), c, 15));
      else
        push(6, c, exp_word(1'b1, 1'b0, 5'b00000, c, 15));
    end
    wait_cyc(a + 15);
    send(2'd0, 4'd15, n);
    wait_cyc(t + 11);

    // 6b: async reset while a command is pending
    send(2'd3, 4'd15, a);
    send(2'd1, 4'd15, m);
    @(negedge clk);
    chk("pend_busy", int'(busy), 1);
    chk("pend_leds", int'({D5, D4, D3, D2, D1}), 5'h1f);
    #2 rstn = 1'b0;
    #1;
    chk("async_leds", int'({D5, D4, D3, D2, D1}), 0);
    chk("async_busy", int'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 2; c <= 20; c++)
      push(7, c, exp_word(1'b1, 1'b0, 5'b00000, c, 15));
    wait_cyc(21);

    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
